// File: rtl/mux_rr_nt1.sv
// Registered N-to-1 valid/ready mux with direct-select and round-robin grant modes.
// Optional macro MUX_XFER_CNT_EN adds a 16-bit output-transfer counter port (xfer_cnt).
module mux_rr_nt1 #(
  parameter int N_CH = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      Sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MUX_XFER_CNT_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  localparam logic [SEL_W:0] N_CH_W = (SEL_W+1)'(N_CH);

  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_ch_q, out_ch_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic                  load_en;
  logic                  gnt_valid;
  logic [SEL_W-1:0]      gnt;
  logic                  xfer;
  logic [2*N_CH-1:0]     vld_dbl;
  logic [N_CH-1:0]       vld_rot;
  logic [SEL_W:0]        rr_sum;

  assign load_en = !out_valid_q || out_ready;
  assign xfer    = load_en && gnt_valid;

  // Round-robin: rotate in_valid so rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    vld_dbl   = {in_valid, in_valid} >> rr_ptr_q;
    vld_rot   = vld_dbl[N_CH-1:0];
    rr_sum    = '0;
    if (!mode) begin
      for (int i = 0; i < N_CH; i++) begin
        if (Sel == SEL_W'(i) && in_valid[i]) begin
          gnt_valid = 1'b1;
          gnt       = SEL_W'(i);
        end
      end
    end else begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        if (vld_rot[k]) begin
          gnt_valid = 1'b1;
          rr_sum    = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
        end
      end
      if (rr_sum >= N_CH_W) begin
        rr_sum = rr_sum - N_CH_W;
      end
      gnt = rr_sum[SEL_W-1:0];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = !rst && xfer && (gnt == SEL_W'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_ch_d    = gnt;
      for (int i = 0; i < N_CH; i++) begin
        if (gnt == SEL_W'(i)) begin
          out_data_d = in_data[i*WIDTH +: WIDTH];
        end
      end
      if (mode) begin
        rr_ptr_d = (gnt == SEL_W'(N_CH - 1)) ? '0 : gnt + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef MUX_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (out_valid_q && out_ready) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_nt1.sv
// Directed table-driven bench for mux_rr_nt1 (N_CH=4, WIDTH=8) plus async-reset sequences.
module tb_mux_rr_nt1;

  localparam logic [31:0] DATA_STD = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef MUX_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  mux_rr_nt1 #(.N_CH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .Sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  vld;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_data;
    logic [1:0]  exp_ch;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;
  logic prev_ov = 1'b0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic m, input logic [1:0] s, input logic [3:0] v,
                      input logic [31:0] d, input logic r, input logic [3:0] erdy,
                      input logic eov, input logic [7:0] ed, input logic [1:0] ech);
    vecs[i].mode = m;     vecs[i].sel = s;      vecs[i].vld = v;
    vecs[i].data = d;     vecs[i].ordy = r;     vecs[i].exp_rdy = erdy;
    vecs[i].exp_ov = eov; vecs[i].exp_data = ed; vecs[i].exp_ch = ech;
  endtask

  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic [31:0] d, input logic r);
    mode = m; sel = s; in_valid = v; in_data = d; out_ready = r;
  endtask

  initial begin
    // Walk from reset: direct select, round-robin, wrap, sparse, backpressure, invalid select.
    setv( 0, 1'b0, 2'd2, 4'b1111, DATA_STD,     1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2);
    setv( 1, 1'b1, 2'd0, 4'b1111, DATA_STD,     1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    setv( 2, 1'b1, 2'd0, 4'b1111, DATA_STD,     1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1);
    setv( 3, 1'b1, 2'd0, 4'b1111, DATA_STD,     1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2);
    setv( 4, 1'b1, 2'd0, 4'b1111, DATA_STD,     1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);
    setv( 5, 1'b1, 2'd0, 4'b1111, DATA_STD,     1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    setv( 6, 1'b1, 2'd0, 4'b1111, DATA_STD,     1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1);
    setv( 7, 1'b1, 2'd0, 4'b1000, DATA_STD,     1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);
    setv( 8, 1'b1, 2'd0, 4'b1010, DATA_STD,     1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1);
    setv( 9, 1'b1, 2'd0, 4'b1010, DATA_STD,     1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);
    setv(10, 1'b1, 2'd0, 4'b1010, DATA_STD,     1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1);
    setv(11, 1'b1, 2'd0, 4'b1010, DATA_STD,     1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);
    setv(12, 1'b1, 2'd0, 4'b0001, DATA_STD,     1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);
    setv(13, 1'b1, 2'd0, 4'b1111, 32'h11223344, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
    setv(14, 1'b1, 2'd0, 4'b1111, 32'h55667788, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
    setv(15, 1'b0, 2'd3, 4'b1111, DATA_STD,     1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
    setv(16, 1'b1, 2'd0, 4'b1111, DATA_STD,     1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1);
    setv(17, 1'b0, 2'd3, 4'b1111, DATA_STD,     1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);
    setv(18, 1'b1, 2'd0, 4'b1111, DATA_STD,     1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2);
    setv(19, 1'b0, 2'd1, 4'b1101, DATA_STD,     1'b1, 4'b0000, 1'b0, 8'hC2, 2'd2);
    setv(20, 1'b0, 2'd1, 4'b1101, DATA_STD,     1'b1, 4'b0000, 1'b0, 8'hC2, 2'd2);
    setv(21, 1'b1, 2'd0, 4'b0000, DATA_STD,     1'b1, 4'b0000, 1'b0, 8'hC2, 2'd2);
    setv(22, 1'b1, 2'd0, 4'b1111, DATA_STD,     1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);
    setv(23, 1'b1, 2'd0, 4'b1111, DATA_STD,     1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0);

    rst = 1'b1;
    drive(1'b0, 2'd0, 4'b1111, DATA_STD, 1'b1);
    #1;
    chk("reset_ready", -1, {28'd0, in_ready}, 32'd0);
    chk("reset_out",   -1, {21'd0, out_valid, out_data, out_ch}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].mode, vecs[i].sel, vecs[i].vld, vecs[i].data, vecs[i].ordy);
      #1;
      chk("in_ready", i, {28'd0, in_ready}, {28'd0, vecs[i].exp_rdy});
      if (prev_ov && vecs[i].ordy) exp_cnt++;
      @(posedge clk);
      #1;
      chk("out", i, {21'd0, out_valid, out_data, out_ch},
          {21'd0, vecs[i].exp_ov, vecs[i].exp_data, vecs[i].exp_ch});
`ifdef MUX_XFER_CNT_EN
      chk("xfer_cnt", i, {16'd0, xfer_cnt}, exp_cnt[31:0]);
`endif
      $display("vec %0d: mode=%0d sel=%0d vld=%b ordy=%0d -> rdy=%b ov=%0d data=%h ch=%0d",
               i, vecs[i].mode, vecs[i].sel, vecs[i].vld, vecs[i].ordy,
               in_ready, out_valid, out_data, out_ch);
      prev_ov = vecs[i].exp_ov;
    end

    // Load channel 3, stall, then hit reset between clock edges.
    @(negedge clk);
    drive(1'b0, 2'd3, 4'b1111, DATA_STD, 1'b1);
    @(posedge clk);
    #1;
    chk("pre_rst_out", 100, {21'd0, out_valid, out_data, out_ch}, {21'd0, 1'b1, 8'hD3, 2'd3});
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out",   101, {21'd0, out_valid, out_data, out_ch}, 32'd0);
    chk("async_rst_ready", 101, {28'd0, in_ready}, 32'd0);
`ifdef MUX_XFER_CNT_EN
    chk("async_rst_cnt",   101, {16'd0, xfer_cnt}, 32'd0);
`endif
    $display("async reset: ov=%0d data=%h ch=%0d rdy=%b", out_valid, out_data, out_ch, in_ready);

    // rr_ptr must restart at 0 after reset.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2'd0, 4'b1111, DATA_STD, 1'b1);
    #1;
    chk("post_rst_ready", 102, {28'd0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst_out", 102, {21'd0, out_valid, out_data, out_ch}, {21'd0, 1'b1, 8'hA0, 2'd0});
    $display("post reset rr: ov=%0d data=%h ch=%0d", out_valid, out_data, out_ch);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_nt1.md
Name: mux_rr_nt1

Overview:
Parametrised, registered N-to-1 multiplexer with valid/ready handshake on every input channel and on the output. It is the next generation of the combinational 4:1 mux. It adds a direct-select mode and a round-robin arbitration mode, plus a one-deep output register. It sits between N producer channels and a single consumer in datapath glue logic.

Parameters:
N_CH, 4, number of input channels (2..16)
WIDTH, 8, data width per channel in bits
SEL_W, $clog2(N_CH), width of select/channel index (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N_CH  per-channel data valid
in_ready  output  N_CH  per-channel accept; combinational
mode  input  1  0 = direct select via Sel, 1 = round-robin
Sel  input  SEL_W  channel index used when mode=0
out_data  output  WIDTH  registered selected data
out_ch  output  SEL_W  registered index of the channel that supplied out_data
out_valid  output  1  registered output valid
out_ready  input  1  consumer accept

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is all zero while rst=1.
- load_en = !out_valid || out_ready. The output register accepts a new word only when load_en=1, giving full throughput with a 1-cycle latency.
- Grant, mode=0:
  - gnt = Sel when in_valid[Sel]=1; otherwise no grant.
  - Sel >= N_CH gives no grant.
  - Other channels never get in_ready.
- Grant, mode=1:
  - Search channels starting at rr_ptr, upward with wrap-around modulo N_CH.
  - The first channel with in_valid=1 is granted.
  - No valid channels means no grant.
- in_ready[i] = load_en && grant_valid && (gnt==i). At most one bit is set, and it is combinational from inputs and state.
- Transfer on channel i: in_valid[i] && in_ready[i] at the clock edge. The edge then does the following:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1.
  - In mode=1 only, rr_ptr <= (i+1) mod N_CH.
- No transfer but out_valid && out_ready: out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous output drain and new load: the new word replaces the old one and out_valid stays 1. No bubble.
- out_valid && !out_ready: out_data, out_ch and out_valid are frozen, and in_ready is all zero. Changes on Sel, mode or in_data do not affect held data.
- rr_ptr does not move in mode=0. Switching mode 0->1 resumes from the stored rr_ptr.
- Wrap-around: when the grant is channel N_CH-1, rr_ptr becomes 0.
- Fairness: with all channels continuously valid and out_ready=1, the grant order in mode=1 is 0,1,...,N_CH-1,0,...
- Reset mid-operation: any held word is discarded immediately (out_valid=0), and rr_ptr returns to 0.

Optional Feature:
Macro MUX_XFER_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [15:0].
  - It increments by 1 on every output transfer (out_valid && out_ready), wraps from 16'hFFFF to 0, and resets to 0 on rst.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Reset check. Assert rst mid-stream with out_valid=1 -> out_valid, out_data, out_ch drop to 0 at once, without waiting for a clock; in_ready=0.
2. Direct select. N_CH=4, WIDTH=8, mode=0, data = {8'hD3,8'hC2,8'hB1,8'hA0}, all valid, Sel=2, out_ready=1.
   - Next edge: out_data=8'hC2, out_ch=2, out_valid=1.
   - Only in_ready[2]=1.
3. Round-robin. mode=1, all valid, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1 with matching data A0,B1,C2,D3,A0,B1.
4. Sparse round-robin. mode=1, in_valid=4'b1010, rr_ptr=0 -> grants 1,3,1,3.
   - Then in_valid=4'b0001 -> grant 0.
5. Backpressure. out_ready=0 with out_valid=1 for 3 cycles while in_data changes -> out_data stable, in_ready=0.
   - Raise out_ready -> next word loads on the same edge, with no bubble cycle.
6. Invalid select. mode=0, Sel=1, in_valid[1]=0 -> no in_ready, and out_valid deasserts after the pending word drains.
   - With MUX_XFER_CNT_EN defined: after 5 output transfers, xfer_cnt=5.
